// File: rtl/bin2gray.sv
// Combinational binary-to-Gray conversion.
// Output bit i is the XOR of binary bits i+1 and i; the MSB passes through.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    always_comb begin
        g = b;
        for (int i = 0; i < WIDTH - 1; i++) begin
            g[i] = b[i+1] ^ b[i];
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down binary counter with a lockstep Gray-coded copy.
// Either wraps modulo 2^WIDTH or saturates at the end values.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] g,
    output logic             wrapped,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             wrapped_q, wrapped_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] step;
    logic             at_end;

    always_comb begin
        step   = up ? bin_q + 1'b1 : bin_q - 1'b1;
        at_end = up ? (bin_q == MAX_VAL) : (bin_q == MIN_VAL);

        bin_d     = bin_q;
        wrapped_d = 1'b0;
        sat_d     = sat_q;

        if (load) begin
            bin_d = load_val;
            sat_d = 1'b0;
        end else if (en) begin
            if (at_end && !WRAP) begin
                sat_d = 1'b1;
            end else begin
                bin_d     = step;
                wrapped_d = WRAP && at_end;
                sat_d     = 1'b0;
            end
        end
    end

    // Convert the muxed next value so g lands on the same edge as bin.
    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .b(bin_d),
        .g(g_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            g_q       <= '0;
            wrapped_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            g_q       <= g_d;
            wrapped_q <= wrapped_d;
            sat_q     <= sat_d;
        end
    end

    assign bin     = bin_q;
    assign g       = g_q;
    assign wrapped = wrapped_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: wrapping and saturating instances share stimulus,
// each checked every cycle against an integer-arithmetic model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] w_bin, w_g, s_bin, s_g;
    logic       w_wr, w_sat, s_wr, s_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin(w_bin), .g(w_g),
        .wrapped(w_wr), .sat(w_sat)
    );

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bin(s_bin), .g(s_g),
        .wrapped(s_wr), .sat(s_sat)
    );

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: index 0 wraps, index 1 saturates.
    int  m_bin[2];
    bit  m_wr[2];
    bit  m_sat[2];
    bit  m_stepped[2];
    bit  started = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int nxt;
            m_stepped[k] = 0;
            if (rst) begin
                m_bin[k] = 0; m_wr[k] = 0; m_sat[k] = 0;
            end else if (load) begin
                m_bin[k] = int'(load_val); m_wr[k] = 0; m_sat[k] = 0;
            end else if (en) begin
                nxt = up ? m_bin[k] + 1 : m_bin[k] - 1;
                if (nxt >= 0 && nxt <= 15) begin
                    m_bin[k] = nxt; m_wr[k] = 0; m_sat[k] = 0;
                    m_stepped[k] = 1;
                end else if (k == 0) begin
                    m_bin[k] = (nxt + 16) % 16; m_wr[k] = 1; m_sat[k] = 0;
                    m_stepped[k] = 1;
                end else begin
                    m_wr[k] = 0; m_sat[k] = 1;
                end
            end else begin
                m_wr[k] = 0;
            end
        end
        started = 1;
    end

    logic [3:0] prev_wg, prev_sg;

    always @(negedge clk) begin
        if (started) begin
            chk("w_bin", w_bin, m_bin[0]);
            chk("w_g", w_g, gray(4'(m_bin[0])));
            chk("w_wrapped", w_wr, m_wr[0]);
            chk("w_sat", w_sat, 0);
            chk("w_g_inv", w_g, gray(w_bin));
            chk("s_bin", s_bin, m_bin[1]);
            chk("s_g", s_g, gray(4'(m_bin[1])));
            chk("s_wrapped", s_wr, 0);
            chk("s_sat", s_sat, m_sat[1]);
            chk("s_g_inv", s_g, gray(s_bin));
            if (m_stepped[0])
                chk("w_onebit", $countones(w_g ^ prev_wg), 1);
            if (m_stepped[1])
                chk("s_onebit", $countones(s_g ^ prev_sg), 1);
        end
        prev_wg = w_g;
        prev_sg = s_g;
    end

    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_bin", w_bin, 0);
        chk("rst_g", w_g, 0);

        // Up count through the wrap.
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 1, 1, 0, 0);
            case (k)
                1:  begin chk("up1_bin", w_bin, 1); chk("up1_g", w_g, 4'b0001); end
                2:  chk("up2_g", w_g, 4'b0011);
                7:  chk("up7_g", w_g, 4'b0100);
                12: chk("up12_g", w_g, 4'b1010);
                15: begin chk("up15_g", w_g, 4'b1000); chk("up15_wr", w_wr, 0); end
                16: begin
                    chk("wrap_bin", w_bin, 0);
                    chk("wrap_g", w_g, 0);
                    chk("wrap_wr", w_wr, 1);
                end
                default: ;
            endcase
        end
        cyc(0, 0, 1, 0, 0);
        chk("wrap_pulse_end", w_wr, 0);

        // Down wrap from zero.
        cyc(0, 0, 1, 1, 4'd0);
        cyc(0, 1, 0, 0, 0);
        chk("dn_bin", w_bin, 15);
        chk("dn_g", w_g, 4'b1000);
        chk("dn_wr", w_wr, 1);
        chk("dn_s_sat", s_sat, 1);
        cyc(0, 1, 0, 0, 0);
        chk("dn2_bin", w_bin, 14);
        chk("dn2_g", w_g, 4'b1001);
        chk("dn2_wr", w_wr, 0);

        // Load beats count.
        cyc(0, 1, 1, 1, 4'd9);
        chk("ld_bin", w_bin, 9);
        chk("ld_g", w_g, 4'b1101);
        cyc(0, 1, 1, 0, 0);
        chk("ld2_bin", w_bin, 10);
        chk("ld2_g", w_g, 4'b1111);

        // Saturation at the top.
        cyc(0, 0, 1, 1, 4'd13);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0);
        chk("sat_bin", s_bin, 15);
        chk("sat_g", s_g, 4'b1000);
        chk("sat_sat", s_sat, 1);
        chk("sat_wr", s_wr, 0);
        cyc(0, 1, 0, 0, 0);
        chk("unsat_bin", s_bin, 14);
        chk("unsat_sat", s_sat, 0);

        // Reset overrides load and count.
        cyc(0, 0, 1, 1, 4'd6);
        chk("pre_rst_g", w_g, 4'b0101);
        cyc(1, 1, 1, 1, 4'd9);
        chk("mid_rst_bin", w_bin, 0);
        chk("mid_rst_g", w_g, 0);
        chk("mid_rst_wr", w_wr, 0);
        chk("mid_rst_sat", s_sat, 0);

        for (int k = 0; k < 1000; k++) begin
            cyc($urandom_range(63) == 0,
                $urandom_range(3) != 0,
                1'($urandom),
                $urandom_range(7) == 0,
                4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down binary counter that produces a Gray-coded copy of its count in the same cycle as the binary value.
- It is the encoding-side partner of the team's combinational Gray-to-binary decoder.
- Intended use: pointer or position generation wherever a single-bit-change code is required, such as async FIFO pointers and encoder emulation.
- Binary-to-Gray conversion lives in a small combinational sub-module. The counter registers both codes.

Parameters:
- WIDTH, 4, counter and code width in bits (min 2).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end values.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- g  output  WIDTH  registered Gray code of bin.
- wrapped  output  1  one-cycle pulse: the last step wrapped (max→0 or 0→max).
- sat  output  1  WRAP=0 only: high while a step was blocked at an end value.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes on the rising edge of clk. All outputs are registers; there are no combinational input-to-output paths.
- Reset values: bin=0, g=0, wrapped=0, sat=0. rst in the middle of counting overrides everything in that cycle; the next cycle shows the reset values.
- Priority, per cycle: rst > load > en > hold.
- Load:
  - bin←load_val and g←bin2gray(load_val).
  - wrapped←0 and sat←0.
  - en and up are ignored in that cycle.
- Count (en=1, no load):
  - Next value nb = bin+1 (up=1) or bin−1 (up=0), truncated to WIDTH bits.
  - bin←nb and g←bin2gray(nb) in the same edge. g is never one cycle behind bin.
- Gray rule: g[W−1]=b[W−1]; g[i]=b[i+1]^b[i] for i<W−1.
- Wrap, WRAP=1:
  - Stepping up from 2^W−1 gives 0; stepping down from 0 gives 2^W−1.
  - wrapped=1 for exactly the cycle following that edge, otherwise 0.
  - sat is tied to 0.
- Saturate, WRAP=0:
  - A step beyond an end value leaves bin and g unchanged and sets sat=1.
  - sat clears on the next accepted step, a load, or rst.
  - wrapped is tied to 0.
- Hold (en=0, no load): bin and g unchanged; wrapped←0; sat keeps its value.
- Invariants, to be asserted by the bench:
  - g == bin2gray(bin) on every cycle.
  - Across any single count step, g differs in exactly one bit. This includes the wrap step.
  - A load may change any number of bits.
- Direction may change on any cycle; there is no penalty or bubble.

Decomposition:
- No shared package. The only constant is WIDTH, passed as a parameter.
- One sub-module, bin2gray (parameter WIDTH): purely combinational binary-to-Gray conversion.
  - Instantiated once, on nb (the muxed next binary value), so that g is registered in lockstep with bin.
  - Reused by the bench as the reference model.

Test Plan (WIDTH=4):
- Up count, WRAP=1: rst, then en=1, up=1 for 16 cycles → bin/g sequence 1/0001, 2/0011, 7/0100, 12/1010, 15/1000, then 0/0000 with wrapped=1 for one cycle only; exactly one g bit toggles per step.
- Down wrap: load_val=0 with load=1, then en=1, up=0 → bin=15, g=1000, wrapped=1; next step gives bin=14, g=1001, wrapped=0.
- Load priority: load=1, load_val=9 with en=1, up=1 in the same cycle → bin=9, g=1101 (not 10); the following count step gives bin=10, g=1111.
- Saturate, WRAP=0: count up to 15, hold en=1, up=1 for 3 more cycles → bin=15, g=1000, sat=1, wrapped=0; then up=0 for one cycle → bin=14, sat=0.
- Reset mid-operation: at bin=6 (g=0101) assert rst with en=1 and load=1 → next cycle bin=0, g=0, wrapped=0, sat=0.
- Random mix of en/up/load over 1000 cycles → scoreboard checks g==bin2gray(bin) every cycle and the one-bit-change property on every count step.
